// File: rtl/axil_master_bridge_if.sv
// Bundle of the native request/response port and the AXI4-Lite initiator port.
// The bridge uses the master modport; the responder/requester side uses the slave modport.
interface axil_master_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  modport master (
    input  req_valid, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp,
    output m_axi_bready,
    output m_axi_arvalid, m_axi_araddr, m_axi_arprot,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    output m_axi_rready
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp,
    input  m_axi_bready,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arprot,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    input  m_axi_rready
  );
endinterface

// File: rtl/axil_master_bridge.sv
// Single-outstanding native-to-AXI4-Lite initiator with per-phase timeout abort.
// All outputs come straight from flops; one transaction in flight at a time.
module axil_master_bridge #(
  parameter int TIMEOUT = 256
) (
  input logic               CLK,
  input logic               RSTb,
  axil_master_bridge_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD, WR, WRESP, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;

  logic        accept, is_rd, tmo;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, wr_addr_done;
  logic        done, done_err;
  logic [31:0] done_rdata;
  logic        unused_resp_lsb;

  assign unused_resp_lsb = ^{bus.m_axi_rresp[0], bus.m_axi_bresp[0]};

  assign accept = bus.req_valid && req_ready_q;
  assign is_rd  = (bus.req_wstrb == 4'b0000);
  assign tmo    = (tmo_cnt_q == CNT_W'(TIMEOUT));
  assign ar_hs  = arvalid_q && bus.m_axi_arready;
  assign r_hs   = rready_q  && bus.m_axi_rvalid;
  assign aw_hs  = awvalid_q && bus.m_axi_awready;
  assign w_hs   = wvalid_q  && bus.m_axi_wready;
  assign b_hs   = bready_q  && bus.m_axi_bvalid;
  // Both address and data channels are clear after this cycle.
  assign wr_addr_done = !(awvalid_q && !bus.m_axi_awready) && !(wvalid_q && !bus.m_axi_wready);

  always_ff @(posedge CLK) begin
    if (!RSTb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: state_d = accept ? (is_rd ? RD : WR) : IDLE;
      RD:         if (r_hs || tmo) state_d = RESP;
      WR: begin
        if (wr_addr_done) state_d = WRESP;
        else if (tmo)     state_d = RESP;
      end
      WRESP:      if (b_hs || tmo) state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    arvalid_d    = arvalid_q && !bus.m_axi_arready;
    rready_d     = rready_q  && !bus.m_axi_rvalid;
    awvalid_d    = awvalid_q && !bus.m_axi_awready;
    wvalid_d     = wvalid_q  && !bus.m_axi_wready;
    bready_d     = bready_q  && !bus.m_axi_bvalid;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    tmo_cnt_d    = '0;
    done         = 1'b0;
    done_err     = 1'b0;
    done_rdata   = '0;
    case (state_q)
      IDLE, RESP: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          wstrb_d     = bus.req_wstrb;
          if (is_rd) begin
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      RD: begin
        // A completing data beat wins over an abort in the same cycle.
        if (r_hs) begin
          done       = 1'b1;
          done_err   = bus.m_axi_rresp[1];
          done_rdata = bus.m_axi_rdata;
        end else if (tmo) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if (!ar_hs) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      WR: begin
        if (wr_addr_done) begin
          bready_d = 1'b1;
        end else if (tmo) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if (!(aw_hs || w_hs)) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      WRESP: begin
        if (b_hs) begin
          done     = 1'b1;
          done_err = bus.m_axi_bresp[1];
        end else if (tmo) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    // Completion or abort: release every AXI valid/ready and present the response.
    if (done) begin
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      resp_valid_d = 1'b1;
      resp_err_d   = done_err;
      resp_rdata_d = done_rdata;
      req_ready_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      tmo_cnt_q    <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      tmo_cnt_q    <= tmo_cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = wstrb_q;
  assign bus.m_axi_bready  = bready_q;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_rready  = rready_q;
endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed bench for axil_master_bridge: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares on every resp_valid pulse.
module tb_axil_master_bridge;
  logic CLK = 1'b0;
  logic RSTb;
  int   tests = 0;
  int   fails = 0;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t exp_q[$];

  axil_master_bridge_if b ();

  axil_master_bridge #(.TIMEOUT(16)) dut (.CLK(CLK), .RSTb(RSTb), .bus(b));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] rd, input logic er);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    b.req_valid = 1'b1;
    b.req_addr  = a;
    b.req_wdata = d;
    b.req_wstrb = s;
  endtask

  always @(negedge CLK) begin
    if (b.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", b.resp_rdata, e.rdata);
        chk("resp_err", {31'd0, b.resp_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    RSTb = 1'b0;
    b.req_valid = 1'b0; b.req_addr = '0; b.req_wdata = '0; b.req_wstrb = '0;
    b.m_axi_awready = 1'b0; b.m_axi_wready = 1'b0;
    b.m_axi_bvalid = 1'b0; b.m_axi_bresp = 2'b00;
    b.m_axi_arready = 1'b0; b.m_axi_rvalid = 1'b0;
    b.m_axi_rdata = '0; b.m_axi_rresp = 2'b00;

    // Reset state
    tick(); tick();
    chk("rst_req_ready", b.req_ready, 0);
    chk("rst_resp_valid", b.resp_valid, 0);
    chk("rst_valids", {b.m_axi_arvalid, b.m_axi_awvalid, b.m_axi_wvalid, b.m_axi_bready, b.m_axi_rready}, 0);
    chk("rst_payload", b.m_axi_awaddr | b.m_axi_wdata | b.resp_rdata, 0);
    RSTb = 1'b1;
    tick();
    chk("rel_req_ready", b.req_ready, 1);

    // Test 1: minimum-latency read
    issue(32'h0000_0004, 32'h0, 4'b0000);
    push(32'h1234_5678, 1'b0);
    tick();
    b.req_valid = 1'b0;
    chk("t1_arvalid", b.m_axi_arvalid, 1);
    chk("t1_araddr", b.m_axi_araddr, 32'h0000_0004);
    chk("t1_rready", b.m_axi_rready, 1);
    chk("t1_req_ready", b.req_ready, 0);
    chk("t1_arprot", {29'd0, b.m_axi_arprot}, 0);
    b.m_axi_arready = 1'b1; b.m_axi_rvalid = 1'b1;
    b.m_axi_rdata = 32'h1234_5678; b.m_axi_rresp = 2'b00;
    tick();
    b.m_axi_arready = 1'b0; b.m_axi_rvalid = 1'b0;
    chk("t1_resp_valid_c2", b.resp_valid, 1);
    chk("t1_arvalid_off", b.m_axi_arvalid, 0);
    chk("t1_req_ready_resp", b.req_ready, 1);
    tick();
    chk("t1_resp_pulse", b.resp_valid, 0);

    // Test 2: write with W before AW and an early ignored bvalid
    issue(32'h1000_0000, 32'hCAFE_BABE, 4'b0011);
    push(32'h0, 1'b0);
    tick();                                   // cycle 1
    b.req_valid = 1'b0;
    chk("t2_awvalid", b.m_axi_awvalid, 1);
    chk("t2_wvalid", b.m_axi_wvalid, 1);
    chk("t2_awaddr", b.m_axi_awaddr, 32'h1000_0000);
    chk("t2_wdata", b.m_axi_wdata, 32'hCAFE_BABE);
    chk("t2_wstrb", {28'd0, b.m_axi_wstrb}, 32'h3);
    chk("t2_bready_c1", b.m_axi_bready, 0);
    b.m_axi_wready = 1'b1;
    tick();                                   // cycle 2
    b.m_axi_wready = 1'b0;
    chk("t2_wvalid_drop", b.m_axi_wvalid, 0);
    chk("t2_awvalid_hold", b.m_axi_awvalid, 1);
    b.m_axi_bvalid = 1'b1; b.m_axi_bresp = 2'b10;
    tick();                                   // cycle 3
    b.m_axi_bvalid = 1'b0; b.m_axi_bresp = 2'b00;
    chk("t2_bready_c3", b.m_axi_bready, 0);
    tick();                                   // cycle 4
    chk("t2_awvalid_c4", b.m_axi_awvalid, 1);
    b.m_axi_awready = 1'b1;
    tick();                                   // cycle 5
    b.m_axi_awready = 1'b0;
    chk("t2_awvalid_drop", b.m_axi_awvalid, 0);
    chk("t2_bready_c5", b.m_axi_bready, 1);
    tick();                                   // cycle 6
    b.m_axi_bvalid = 1'b1; b.m_axi_bresp = 2'b00;
    tick();                                   // cycle 7
    b.m_axi_bvalid = 1'b0;
    chk("t2_resp_valid_c7", b.resp_valid, 1);
    chk("t2_bready_off", b.m_axi_bready, 0);
    tick();

    // Test 3: read with SLVERR, AR and R in separate cycles
    issue(32'h0000_0020, 32'h0, 4'b0000);
    push(32'hDEAD_BEEF, 1'b1);
    tick();
    b.req_valid = 1'b0;
    b.m_axi_arready = 1'b1;
    tick();
    b.m_axi_arready = 1'b0;
    chk("t3_arvalid_drop", b.m_axi_arvalid, 0);
    chk("t3_rready_hold", b.m_axi_rready, 1);
    b.m_axi_rvalid = 1'b1; b.m_axi_rdata = 32'hDEAD_BEEF; b.m_axi_rresp = 2'b10;
    tick();
    b.m_axi_rvalid = 1'b0; b.m_axi_rresp = 2'b00;
    chk("t3_resp_valid", b.resp_valid, 1);
    tick();

    // Test 4: responder never takes AR -> abort
    issue(32'h0000_0040, 32'h0, 4'b0000);
    push(32'h0, 1'b1);
    b.m_axi_rdata = 32'hFFFF_FFFF;
    tick();                                   // cycle 1: arvalid rises
    b.req_valid = 1'b0;
    chk("t4_arvalid", b.m_axi_arvalid, 1);
    got = 0;
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (k == 17) chk("t4_arvalid_c17", b.m_axi_arvalid, 1);
      if (b.resp_valid) begin
        got = k;
        chk("t4_arvalid_abort", b.m_axi_arvalid, 0);
        chk("t4_rready_abort", b.m_axi_rready, 0);
        chk("t4_req_ready", b.req_ready, 1);
        break;
      end
    end
    chk("t4_abort_cycle", got, 18);
    tick();

    // Test 5: req_valid held for two back-to-back reads
    issue(32'h0000_0100, 32'h0, 4'b0000);
    push(32'h1111_1111, 1'b0);
    push(32'h2222_2222, 1'b0);
    tick();                                   // cycle 1
    b.req_addr = 32'h0000_0104;
    chk("t5_araddr_a", b.m_axi_araddr, 32'h0000_0100);
    b.m_axi_arready = 1'b1; b.m_axi_rvalid = 1'b1; b.m_axi_rdata = 32'h1111_1111;
    tick();                                   // cycle 2
    b.m_axi_arready = 1'b0; b.m_axi_rvalid = 1'b0;
    chk("t5_resp_a", b.resp_valid, 1);
    chk("t5_req_ready_resp", b.req_ready, 1);
    tick();                                   // cycle 3
    b.req_valid = 1'b0;
    chk("t5_arvalid_b", b.m_axi_arvalid, 1);
    chk("t5_araddr_b", b.m_axi_araddr, 32'h0000_0104);
    chk("t5_req_ready_busy", b.req_ready, 0);
    b.m_axi_arready = 1'b1; b.m_axi_rvalid = 1'b1; b.m_axi_rdata = 32'h2222_2222;
    tick();                                   // cycle 4
    b.m_axi_arready = 1'b0; b.m_axi_rvalid = 1'b0;
    chk("t5_resp_b", b.resp_valid, 1);
    tick();

    // Test 6: reset mid-write discards the transaction
    issue(32'h3000_0000, 32'h5555_AAAA, 4'b1111);
    tick();
    b.req_valid = 1'b0;
    chk("t6_awvalid", b.m_axi_awvalid, 1);
    chk("t6_wvalid", b.m_axi_wvalid, 1);
    RSTb = 1'b0;
    tick();
    chk("t6_rst_valids", {b.m_axi_awvalid, b.m_axi_wvalid, b.m_axi_bready, b.resp_valid, b.req_ready}, 0);
    chk("t6_rst_payload", b.m_axi_awaddr | b.m_axi_wdata, 0);
    RSTb = 1'b1;
    tick();
    chk("t6_req_ready", b.req_ready, 1);
    chk("t6_awvalid_idle", b.m_axi_awvalid, 0);
    for (int k = 0; k < 6; k++) tick();

    chk("pending_responses", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
